adc_sample_packer: RTL

// - Packs ADC samples (downsampled, parametrised width) into WORD_W words on one clock domain.
// - Controls capture: arm, trigger, N segments of max_samples each, or unbounded stream mode.
// - Feeds a downstream FIFO/DMA over a valid/ready interface with a one-word output register.
// - Successor to the fixed 10-bit/3-per-32-bit packer; adds generic packing, segmentation and a handshake.

---
 rtl/adc_sample_packer_if.sv | 23 ++
 rtl/adc_sample_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_packer_if.sv
// Output word stream of adc_sample_packer: one registered word with lane count, segment markers and overrange flag.
interface adc_sample_packer_if #(
    parameter int WORD_W = 64,
    parameter int NS_W   = 3
);
    logic [WORD_W-1:0] out_data;
    logic [NS_W-1:0]   out_nsamp;
    logic              out_first;
    logic              out_last;
    logic              out_or;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data, out_nsamp, out_first, out_last, out_or, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_nsamp, out_first, out_last, out_or, out_valid,
        output out_ready
    );
endinterface

// File: rtl/adc_sample_packer.sv
// Downsamples and packs ADC samples into WORD_W words; out_valid rises 1 cycle after the completing sample (ADC_OR_FLAG_EN adds out_or).
// Backpressure: a word completing while the output register is still held is dropped, overflow_o sets and capture stops.
module adc_sample_packer #(
    parameter int SAMPLE_W = 12,
    parameter int WORD_W   = 64,
    parameter int DS_W     = 16,
    parameter int CNT_W    = 32,
    parameter int SEG_W    = 8
) (
    input  logic                 adc_sampleclk,
    input  logic                 reset_n,
    input  logic                 arm_i,
    input  logic                 stream_mode_i,
    input  logic                 trig_i,
    input  logic [SAMPLE_W-1:0]  adc_datain,
    input  logic                 adc_or,
    input  logic [DS_W-1:0]      downsample_i,
    input  logic [CNT_W-1:0]     max_samples_i,
    input  logic [SEG_W-1:0]     num_segments_i,
    adc_sample_packer_if.master  out_if,
    output logic                 armed_o,
    output logic                 capture_done_o,
    output logic                 overflow_o,
    output logic [CNT_W-1:0]     samples_o
);
    localparam int PACK = WORD_W / SAMPLE_W;
    localparam int NS_W = $clog2(PACK + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_REARM} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_arm_d;
    logic [DS_W-1:0]     r_ds_ctr;
    logic [CNT_W-1:0]    r_seg_left;
    logic [SEG_W-1:0]    r_seg_done;
    logic [NS_W-1:0]     r_lane;
    logic [WORD_W-1:0]   r_pack;
    logic                r_first_pend;
    logic                r_overflow;
    logic                r_cap_done;
    logic [CNT_W-1:0]    r_samples;
    logic [WORD_W-1:0]   r_out_data;
    logic [NS_W-1:0]     r_out_nsamp;
    logic                r_out_first;
    logic                r_out_last;
    logic                r_out_valid;

    logic                w_arm_edge;
    logic                w_start;
    logic                w_keep;
    logic                w_seg_final;
    logic                w_complete;
    logic                w_can_load;
    logic                w_load;
    logic                w_ovf;
    logic                w_seg_end;
    logic                w_more_segs;
    logic [SEG_W:0]      w_seg_tgt;
    logic [WORD_W-1:0]   w_pack_nxt;

    // The downsample counter restarts at 0 on trigger and keeps on 0, so the first capture cycle is always kept.
    always_comb begin
        w_arm_edge  = (r_state == S_IDLE) && arm_i && !r_arm_d;
        w_start     = (r_state == S_ARMED) && arm_i && trig_i;
        w_keep      = (r_state == S_CAPTURE) && arm_i && (r_ds_ctr == '0);
        w_seg_final = w_keep && !stream_mode_i && (r_seg_left == CNT_W'(1));
        w_complete  = w_keep && ((r_lane == NS_W'(PACK - 1)) || w_seg_final);
        w_can_load  = !r_out_valid || out_if.out_ready;
        w_load      = w_complete && w_can_load;
        w_ovf       = w_complete && !w_can_load;
        w_seg_end   = w_load && w_seg_final;
        w_seg_tgt   = (num_segments_i == '0) ? (SEG_W + 1)'(1) : {1'b0, num_segments_i};
        w_more_segs = ({1'b0, r_seg_done} + (SEG_W + 1)'(1)) < w_seg_tgt;
        w_pack_nxt  = r_pack;
        for (int k = 0; k < PACK; k++) begin
            if (r_lane == NS_W'(k)) begin
                w_pack_nxt[k*SAMPLE_W +: SAMPLE_W] = adc_datain;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state != S_IDLE && !arm_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_arm_edge) w_state_nxt = S_ARMED;
                S_ARMED:   if (trig_i) w_state_nxt = S_CAPTURE;
                S_CAPTURE: begin
                    if (w_ovf) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_seg_end) begin
                        w_state_nxt = w_more_segs ? S_REARM : S_IDLE;
                    end
                end
                S_REARM:   if (!trig_i) w_state_nxt = S_ARMED;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_sampleclk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge adc_sampleclk) begin
        if (!reset_n) begin
            r_arm_d      <= 1'b0;
            r_ds_ctr     <= '0;
            r_seg_left   <= '0;
            r_seg_done   <= '0;
            r_lane       <= '0;
            r_pack       <= '0;
            r_first_pend <= 1'b0;
            r_overflow   <= 1'b0;
            r_cap_done   <= 1'b0;
            r_samples    <= '0;
            r_out_data   <= '0;
            r_out_nsamp  <= '0;
            r_out_first  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_arm_d    <= arm_i;
            r_cap_done <= w_seg_end && !w_more_segs;
            if (w_arm_edge) begin
                r_overflow <= 1'b0;
                r_samples  <= '0;
                r_seg_done <= '0;
            end
            if (w_start) begin
                r_ds_ctr     <= '0;
                r_seg_left   <= (max_samples_i == '0) ? CNT_W'(1) : max_samples_i;
                r_lane       <= '0;
                r_pack       <= '0;
                r_first_pend <= 1'b1;
            end
            if (r_state == S_CAPTURE && arm_i) begin
                r_ds_ctr <= (r_ds_ctr == downsample_i) ? '0 : r_ds_ctr + DS_W'(1);
            end
            if (w_keep) begin
                if (r_samples != '1) begin
                    r_samples <= r_samples + CNT_W'(1);
                end
                r_seg_left <= r_seg_left - CNT_W'(1);
                if (w_complete) begin
                    r_lane <= '0;
                    r_pack <= '0;
                end else begin
                    r_lane <= r_lane + NS_W'(1);
                    r_pack <= w_pack_nxt;
                end
            end
            if (w_seg_end) begin
                r_seg_done <= r_seg_done + SEG_W'(1);
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_pack_nxt;
                r_out_nsamp  <= r_lane + NS_W'(1);
                r_out_first  <= r_first_pend;
                r_out_last   <= w_seg_final;
                r_first_pend <= 1'b0;
            end else if (out_if.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef ADC_OR_FLAG_EN
    logic r_or_acc;
    logic r_out_or;
    logic w_or_nxt;

    assign w_or_nxt = r_or_acc | adc_or;

    always_ff @(posedge adc_sampleclk) begin
        if (!reset_n) begin
            r_or_acc <= 1'b0;
            r_out_or <= 1'b0;
        end else begin
            if (w_start) begin
                r_or_acc <= 1'b0;
            end else if (w_keep) begin
                r_or_acc <= w_complete ? 1'b0 : w_or_nxt;
            end
            if (w_load) begin
                r_out_or <= w_or_nxt;
            end
        end
    end

    assign out_if.out_or = r_out_or;
`else
    logic w_unused_or;
    assign w_unused_or   = adc_or;
    assign out_if.out_or = 1'b0;
`endif

    assign out_if.out_data  = r_out_data;
    assign out_if.out_nsamp = r_out_nsamp;
    assign out_if.out_first = r_out_first;
    assign out_if.out_last  = r_out_last;
    assign out_if.out_valid = r_out_valid;
    assign armed_o          = (r_state != S_IDLE);
    assign capture_done_o   = r_cap_done;
    assign overflow_o       = r_overflow;
    assign samples_o        = r_samples;
endmodule
